// File: rtl/neuron_serial_mac.sv
// Serial-MAC neuron: accumulates N_INPUTS 12-bit float products into a saturating fixed-point
// register, applies a selectable activation and renormalises the result back to 12-bit float.
module neuron_serial_mac #(
    parameter int N_INPUTS = 4,
    parameter int ACC_INT  = 20,
    parameter int ACC_FRAC = 12
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_in_valid,
    output logic       o_in_ready,
    input  logic       i_sign_x,
    input  logic [4:0] i_exponent_x,
    input  logic [5:0] i_mantissa_x,
    input  logic       i_sign_w,
    input  logic [4:0] i_exponent_w,
    input  logic [5:0] i_mantissa_w,
    input  logic [1:0] i_mode,
    output logic       o_out_valid,
    input  logic       i_out_ready,
    output logic       o_sign_out,
    output logic [4:0] o_exponent_out,
    output logic [5:0] o_mantissa_out
);

    localparam int ACC_W  = ACC_INT + ACC_FRAC;
    localparam int WIDE_W = ACC_W + 14;
    localparam int CNT_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

    localparam logic [CNT_W-1:0]       LAST    = CNT_W'(N_INPUTS - 1);
    localparam logic signed [ACC_W:0]  WMAX    = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0]  WMIN    = -WMAX;
    localparam logic signed [ACC_W:0]  ONE     = {{(ACC_W-ACC_FRAC){1'b0}}, 1'b1, {ACC_FRAC{1'b0}}};
    localparam logic signed [ACC_W:0]  NEG_ONE = -ONE;
    localparam logic signed [ACC_W:0]  HALF    =
        {{(ACC_W-ACC_FRAC+1){1'b0}}, 1'b1, {(ACC_FRAC-1){1'b0}}};

    typedef enum logic [1:0] {StAccum, StAct, StNorm, StOut} state_e;

    state_e                  r_state;
    logic [CNT_W-1:0]        r_count;
    logic [1:0]              r_mode;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W:0]   r_act;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic                    r_sign_out;
    logic [4:0]              r_exponent_out;
    logic [5:0]              r_mantissa_out;

    logic                    w_accept;
    logic [13:0]             w_mag14;
    logic [WIDE_W-1:0]       w_wide;
    logic [ACC_W-1:0]        w_prod_mag;
    logic signed [ACC_W-1:0] w_prod;
    logic signed [ACC_W:0]   w_sum;
    logic signed [ACC_W-1:0] w_acc_next;
    int                      w_shift;

    assign w_accept = i_in_valid & r_in_ready;

    // Product magnitude is saturated to ACC_W-1 bits before it ever reaches the adder.
    always_comb begin
        w_mag14    = {1'b1, i_mantissa_x} * {1'b1, i_mantissa_w};
        w_shift    = int'(i_exponent_x) + int'(i_exponent_w) - 30 + (ACC_FRAC - 12);
        w_wide     = '0;
        w_prod_mag = '0;
        if (i_exponent_x == 5'd0 || i_exponent_w == 5'd0) begin
            w_prod_mag = '0;
        end else if (w_shift >= 0) begin
            if (w_shift >= ACC_W) begin
                w_prod_mag = WMAX[ACC_W-1:0];
            end else begin
                w_wide = {{ACC_W{1'b0}}, w_mag14} << w_shift;
                if (|w_wide[WIDE_W-1:ACC_W-1]) begin
                    w_prod_mag = WMAX[ACC_W-1:0];
                end else begin
                    w_prod_mag = w_wide[ACC_W-1:0];
                end
            end
        end else if (-w_shift < ACC_W) begin
            w_wide     = {{ACC_W{1'b0}}, w_mag14} >> (-w_shift);
            w_prod_mag = w_wide[ACC_W-1:0];
        end
        w_prod = (i_sign_x ^ i_sign_w) ? -w_prod_mag : w_prod_mag;
        w_sum  = {r_acc[ACC_W-1], r_acc} + {w_prod[ACC_W-1], w_prod};
        if (w_sum > WMAX) begin
            w_acc_next = WMAX[ACC_W-1:0];
        end else if (w_sum < WMIN) begin
            w_acc_next = WMIN[ACC_W-1:0];
        end else begin
            w_acc_next = w_sum[ACC_W-1:0];
        end
    end

    logic signed [ACC_W:0] w_acc_ext;
    logic signed [ACC_W:0] w_sig;
    logic signed [ACC_W:0] w_act;

    always_comb begin
        w_acc_ext = {r_acc[ACC_W-1], r_acc};
        w_sig     = (w_acc_ext >>> 2) + HALF;
        w_act     = w_acc_ext;
        case (r_mode)
            2'd0: w_act = w_acc_ext;
            2'd1: w_act = w_acc_ext[ACC_W] ? '0 : w_acc_ext;
            2'd2: begin
                if (w_acc_ext > ONE) begin
                    w_act = ONE;
                end else if (w_acc_ext < NEG_ONE) begin
                    w_act = NEG_ONE;
                end else begin
                    w_act = w_acc_ext;
                end
            end
            2'd3: begin
                if (w_sig[ACC_W]) begin
                    w_act = '0;
                end else if (w_sig > ONE) begin
                    w_act = ONE;
                end else begin
                    w_act = w_sig;
                end
            end
            default: w_act = w_acc_ext;
        endcase
    end

    logic [ACC_W:0] w_abs;
    int             w_lead;
    int             w_exp;
    logic [5:0]     w_mant;
    logic           w_norm_sign;
    logic [4:0]     w_norm_exp;
    logic [5:0]     w_norm_mant;

    // Mantissa bits are picked by constant indices so bits below bit 0 simply stay zero.
    always_comb begin
        w_abs  = r_act[ACC_W] ? -r_act : r_act;
        w_lead = 0;
        for (int i = 0; i <= ACC_W; i++) begin
            if (w_abs[i]) begin
                w_lead = i;
            end
        end
        w_mant = '0;
        for (int i = 0; i <= ACC_W; i++) begin
            for (int j = 0; j < 6; j++) begin
                if (i == w_lead - 1 - j) begin
                    w_mant[5-j] = w_abs[i];
                end
            end
        end
        w_exp = w_lead - ACC_FRAC + 15;
        if (w_abs == '0 || w_exp < 1) begin
            w_norm_sign = 1'b0;
            w_norm_exp  = 5'd0;
            w_norm_mant = 6'd0;
        end else if (w_exp > 31) begin
            w_norm_sign = r_act[ACC_W];
            w_norm_exp  = 5'd31;
            w_norm_mant = 6'd63;
        end else begin
            w_norm_sign = r_act[ACC_W];
            w_norm_exp  = 5'(w_exp);
            w_norm_mant = w_mant;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= StAccum;
            r_count        <= '0;
            r_mode         <= 2'd0;
            r_acc          <= '0;
            r_act          <= '0;
            r_in_ready     <= 1'b1;
            r_out_valid    <= 1'b0;
            r_sign_out     <= 1'b0;
            r_exponent_out <= 5'd0;
            r_mantissa_out <= 6'd0;
        end else begin
            case (r_state)
                StAccum: begin
                    if (w_accept) begin
                        if (r_count == '0) begin
                            r_mode <= i_mode;
                        end
                        r_acc <= w_acc_next;
                        if (r_count == LAST) begin
                            r_count    <= '0;
                            r_in_ready <= 1'b0;
                            r_state    <= StAct;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                StAct: begin
                    r_act   <= w_act;
                    r_state <= StNorm;
                end
                StNorm: begin
                    r_sign_out     <= w_norm_sign;
                    r_exponent_out <= w_norm_exp;
                    r_mantissa_out <= w_norm_mant;
                    r_out_valid    <= 1'b1;
                    r_state        <= StOut;
                end
                StOut: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_acc       <= '0;
                        r_count     <= '0;
                        r_state     <= StAccum;
                    end
                end
                default: r_state <= StAccum;
            endcase
        end
    end

    assign o_in_ready     = r_in_ready;
    assign o_out_valid    = r_out_valid;
    assign o_sign_out     = r_sign_out;
    assign o_exponent_out = r_exponent_out;
    assign o_mantissa_out = r_mantissa_out;

endmodule
